tinker_mem_arbiter: RTL and testbench

Single-port memory arbiter and access sequencer for the Tinker core. It shares the one `memory_unit` port between the instruction-fetch requester and the data requester (load/store, call/return stack traffic). It grants one transaction at a time, drives the memory enables for a fixed access latency, and returns the response to the owning requester. It sits between the core control FSM and `memory_unit`.

---
 rtl/tinker_pkg.sv | 21 ++
 rtl/tinker_arb_picker.sv | 35 +++
 rtl/tinker_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_tinker_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker memory arbiter.
// Holds FSM states, requester ids and the access-latency bound.
package tinker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    // Pointer reset value: data wins the first tie under round-robin.
    localparam req_id_t FETCH_LAST = REQ_FETCH;

    localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/tinker_arb_picker.sv
// Requester picker: chooses fetch or data when both are valid (TINKER_ARB_RR_EN selects round-robin).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the grant is only honoured by the caller while idle.
module tinker_arb_picker
    import tinker_pkg::*;
(
    input  logic    if_valid,
    input  logic    d_valid,
    input  req_id_t last_grant,
    output req_id_t grant,
    output logic    any_valid
);

`ifdef TINKER_ARB_RR_EN
    always_comb begin
        any_valid = if_valid | d_valid;
        grant     = REQ_FETCH;
        if (if_valid && d_valid) begin
            grant = (last_grant == REQ_DATA) ? REQ_FETCH : REQ_DATA;
        end else if (d_valid) begin
            grant = REQ_DATA;
        end
    end
`else
    // Fixed priority has no use for the pointer.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        any_valid = if_valid | d_valid;
        grant     = d_valid ? REQ_DATA : REQ_FETCH;
    end
`endif

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Single-port memory arbiter/sequencer between fetch and data requesters (TINKER_ARB_RR_EN: round-robin).
// Latency: grant at T, memory access T+1..T+MEM_LAT, response pulse at T+MEM_LAT+1.
// Backpressure: ready only in IDLE for the picked requester; one transaction in flight.
module tinker_mem_arbiter
    import tinker_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        cnt_q;
    req_id_t           owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    req_id_t grant;
    req_id_t last_grant;
    logic    any_valid;
    logic    hs;

    tinker_arb_picker u_picker (
        .if_valid   (if_req_valid),
        .d_valid    (d_req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    assign hs = (state_q == IDLE) && any_valid;

`ifdef TINKER_ARB_RR_EN
    req_id_t last_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= FETCH_LAST;
        end else if (hs) begin
            last_q <= grant;
        end
    end
    assign last_grant = last_q;
`else
    assign last_grant = FETCH_LAST;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        if_rsp_valid = 1'b0;
        d_rsp_valid  = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        case (state_q)
            IDLE: begin
                if_req_ready = if_req_valid && (grant == REQ_FETCH);
                d_req_ready  = d_req_valid && (grant == REQ_DATA);
                if (any_valid) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr     = addr_q;
                mem_wdata    = wdata_q;
                mem_read_en  = !we_q;
                // The counter starts at LAT_M1, so this marks the first access cycle.
                mem_write_en = we_q && (cnt_q == LAT_M1);
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if_rsp_valid = (owner_q == REQ_FETCH);
                d_rsp_valid  = (owner_q == REQ_DATA);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            owner_q <= REQ_FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (hs) begin
            cnt_q   <= LAT_M1;
            owner_q <= grant;
            we_q    <= (grant == REQ_DATA) && d_req_we;
            addr_q  <= (grant == REQ_DATA) ? d_req_addr : if_req_addr;
            wdata_q <= (grant == REQ_DATA) ? d_req_wdata : '0;
        end else if (state_q == ACCESS) begin
            if (cnt_q == 4'd0) begin
                rdata_q <= we_q ? '0 : mem_rdata;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign if_rsp_data = rdata_q[31:0];
    assign d_rsp_data  = rdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Directed bench: MEM_LAT=2 instance for the vector table and corner sequences, MEM_LAT=1 instance for back-to-back loads.
module tb_tinker_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // MEM_LAT = 2 instance
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [63:0] if_req_addr;
    logic [31:0] if_rsp_data;
    logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
    logic [63:0] d_req_addr, d_req_wdata, d_rsp_data;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read_en, mem_write_en, busy;

    tinker_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2)) u_dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    logic [63:0] mem [0:2047];
    logic        pre_we = 1'b0;
    logic [10:0] pre_idx = '0;
    logic [63:0] pre_dat = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_dat;
        else if (mem_write_en) mem[mem_addr[13:3]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[13:3]];

    // MEM_LAT = 1 instance with an address-derived memory image
    logic        b_if_req_valid, b_if_req_ready, b_if_rsp_valid;
    logic [63:0] b_if_req_addr;
    logic [31:0] b_if_rsp_data;
    logic        b_d_req_valid, b_d_req_we, b_d_req_ready, b_d_rsp_valid;
    logic [63:0] b_d_req_addr, b_d_req_wdata, b_d_rsp_data;
    logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_read_en, b_mem_write_en, b_busy;

    tinker_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req_valid(b_if_req_valid), .if_req_addr(b_if_req_addr), .if_req_ready(b_if_req_ready),
        .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data),
        .d_req_valid(b_d_req_valid), .d_req_we(b_d_req_we), .d_req_addr(b_d_req_addr),
        .d_req_wdata(b_d_req_wdata), .d_req_ready(b_d_req_ready),
        .d_rsp_valid(b_d_rsp_valid), .d_rsp_data(b_d_rsp_data),
        .mem_addr(b_mem_addr), .mem_read_en(b_mem_read_en), .mem_write_en(b_mem_write_en),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [63:0] img1(input logic [63:0] a);
        return {32'hA5A5_0000 ^ a[31:0], a[31:0]};
    endfunction
    assign b_mem_rdata = img1(b_mem_addr);

    int          rsp_cyc[$];
    logic [63:0] rsp_dat[$];
    always @(negedge clk) begin
        if (b_d_rsp_valid) begin
            rsp_cyc.push_back(cyc);
            rsp_dat.push_back(b_d_rsp_data);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [10:0] i, input logic [63:0] d);
        pre_idx = i;
        pre_dat = d;
        pre_we  = 1'b1;
        tick();
        pre_we  = 1'b0;
    endtask

    typedef struct {
        logic        if_v;
        logic [63:0] if_a;
        logic        d_v;
        logic        d_we;
        logic [63:0] d_a;
        logic [63:0] d_wd;
        logic        g_data;   // expected winner: 1 = data
        logic [63:0] exp;      // expected response data on the winner's port
    } vec_t;

    localparam int NV = 7;
    vec_t        vecs[NV];
    vec_t        v;
    logic [63:0] wa;
    logic        st;
    logic [1:0]  exp_g2;
    logic        seen;
    int          hs_cyc[4];
    logic [63:0] b_addrs[4];
    int          k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        if_req_valid = 0; if_req_addr = '0; d_req_valid = 0; d_req_we = 0;
        d_req_addr = '0; d_req_wdata = '0;
        b_if_req_valid = 0; b_if_req_addr = '0; b_d_req_valid = 0; b_d_req_we = 0;
        b_d_req_addr = '0; b_d_req_wdata = '0;

        vecs[0] = '{1'b1, 64'h2000, 1'b0, 1'b0, 64'h0,    64'h0,                  1'b0, 64'h8A40_0000};
        vecs[1] = '{1'b0, 64'h0,    1'b1, 1'b1, 64'h1000, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 64'h0};
        vecs[2] = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h1000, 64'h0,                  1'b1, 64'hDEAD_BEEF_CAFE_F00D};
`ifdef TINKER_ARB_RR_EN
        vecs[3] = '{1'b1, 64'h3000, 1'b1, 1'b0, 64'h1008, 64'h0,                  1'b0, 64'h1234_5678};
`else
        vecs[3] = '{1'b1, 64'h3000, 1'b1, 1'b0, 64'h1008, 64'h0,                  1'b1, 64'h1122_3344_5566_7788};
`endif
        vecs[4] = '{1'b1, 64'h3000, 1'b0, 1'b0, 64'h0,    64'h0,                  1'b0, 64'h1234_5678};
        vecs[5] = '{1'b1, 64'h2000, 1'b1, 1'b1, 64'h1008, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0};
        vecs[6] = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h1008, 64'h0,                  1'b1, 64'h0123_4567_89AB_CDEF};

        preload(11'h400, 64'h0000_0000_8A40_0000);
        preload(11'h201, 64'h1122_3344_5566_7788);
        preload(11'h600, 64'h0BAD_F00D_1234_5678);

        @(negedge clk);
        chk("reset_flags", 64'({if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid,
                                mem_read_en, mem_write_en, busy}), 64'h0);
        chk("reset_mem_addr", mem_addr, 64'h0);
        chk("reset_rsp_data", d_rsp_data | 64'(if_rsp_data), 64'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            tick();
            if_req_valid = v.if_v; if_req_addr = v.if_a;
            d_req_valid = v.d_v; d_req_we = v.d_we; d_req_addr = v.d_a; d_req_wdata = v.d_wd;
            @(negedge clk);
            chk($sformatf("v%0d_if_ready", i), 64'(if_req_ready), 64'(v.if_v && !v.g_data));
            chk($sformatf("v%0d_d_ready", i), 64'(d_req_ready), 64'(v.g_data));
            tick();
            if_req_valid = 0; d_req_valid = 0; d_req_we = 0;
            wa = v.g_data ? v.d_a : v.if_a;
            st = v.g_data && v.d_we;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                chk($sformatf("v%0d_acc%0d_en", i, c), 64'({mem_read_en, mem_write_en}),
                    64'({!st, st && (c == 0)}));
                chk($sformatf("v%0d_acc%0d_addr", i, c), mem_addr, wa);
                if (st) chk($sformatf("v%0d_acc%0d_wdata", i, c), mem_wdata, v.d_wd);
                tick();
            end
            @(negedge clk);
            chk($sformatf("v%0d_rsp_vld", i), 64'({if_rsp_valid, d_rsp_valid}), 64'({!v.g_data, v.g_data}));
            chk($sformatf("v%0d_rsp_dat", i), v.g_data ? d_rsp_data : 64'(if_rsp_data), v.exp);
            tick();
            @(negedge clk);
            chk($sformatf("v%0d_idle", i), 64'({if_rsp_valid, d_rsp_valid, busy}), 64'h0);
        end

        // Reset during the second access cycle of a load.
        tick();
        d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h1008;
        @(negedge clk);
        chk("rst_hs", 64'(d_req_ready), 64'h1);
        tick();
        d_req_valid = 0;
        tick();
        @(negedge clk);
        chk("rst_pre_read_en", 64'(mem_read_en), 64'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_flags", 64'({if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid,
                                  mem_read_en, mem_write_en, busy}), 64'h0);
        chk("rst_mid_addr", mem_addr, 64'h0);
        chk("rst_mid_data", d_rsp_data, 64'h0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (d_rsp_valid || busy || mem_read_en) seen = 1'b1;
        end
        chk("rst_no_rsp", 64'(seen), 64'h0);

        // Both held valid: data first, then fetch (round-robin) or data again (fixed).
`ifdef TINKER_ARB_RR_EN
        exp_g2 = 2'b10;
`else
        exp_g2 = 2'b01;
`endif
        tick();
        if_req_valid = 1; if_req_addr = 64'h2000;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h1008;
        @(negedge clk);
        chk("tie1_grant", 64'({if_req_ready, d_req_ready}), 64'h1);
        tick();
        @(negedge clk);
        chk("tie_no_ready_busy", 64'({if_req_ready, d_req_ready}), 64'h0);
        tick();
        tick();
        @(negedge clk);
        chk("tie1_rsp_vld", 64'({if_rsp_valid, d_rsp_valid}), 64'h1);
        chk("tie1_rsp_dat", d_rsp_data, 64'h0123_4567_89AB_CDEF);
        tick();
        @(negedge clk);
        chk("tie2_grant", 64'({if_req_ready, d_req_ready}), 64'(exp_g2));
        tick();
        if_req_valid = 0; d_req_valid = 0;
        tick();
        tick();
        @(negedge clk);
        chk("tie2_rsp_vld", 64'({if_rsp_valid, d_rsp_valid}), 64'(exp_g2));
        chk("tie2_rsp_dat", exp_g2[1] ? 64'(if_rsp_data) : d_rsp_data,
            exp_g2[1] ? 64'h8A40_0000 : 64'h0123_4567_89AB_CDEF);
        tick();

        // Fetch valid raised during a data transaction and dropped before IDLE.
        tick();
        d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h1000;
        @(negedge clk);
        chk("drop_d_hs", 64'(d_req_ready), 64'h1);
        tick();
        d_req_valid = 0; if_req_valid = 1; if_req_addr = 64'h3000;
        @(negedge clk);
        chk("drop_if_blocked", 64'(if_req_ready), 64'h0);
        tick();
        tick();
        @(negedge clk);
        chk("drop_d_rsp", 64'({d_rsp_valid, if_rsp_valid}), 64'h2);
        chk("drop_d_dat", d_rsp_data, 64'hDEAD_BEEF_CAFE_F00D);
        if_req_valid = 0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (if_req_ready || if_rsp_valid || busy || mem_read_en || mem_write_en) seen = 1'b1;
        end
        chk("drop_no_activity", 64'(seen), 64'h0);

        // MEM_LAT = 1: four back-to-back loads.
        b_addrs[0] = 64'h40; b_addrs[1] = 64'h48; b_addrs[2] = 64'h1F0; b_addrs[3] = 64'h7777_0000;
        for (int i = 0; i < 4; i++) begin
            b_d_req_valid = 1; b_d_req_we = 0; b_d_req_addr = b_addrs[i];
            k = 0;
            @(negedge clk);
            while (!b_d_req_ready && k < 10) begin
                tick();
                @(negedge clk);
                k++;
            end
            if (!b_d_req_ready) begin
                n_chk++; n_err++;
                $display("FAIL bb%0d_grant_timeout: ready=%b required 1", i, b_d_req_ready);
            end
            hs_cyc[i] = cyc;
            if (i > 0) chk($sformatf("bb%0d_gap", i), 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);
            tick();
        end
        b_d_req_valid = 0;
        for (int c = 0; c < 4; c++) tick();
        chk("bb_rsp_count", 64'(rsp_cyc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rsp_cyc.size()) begin
                chk($sformatf("bb%0d_rsp_cycle", i), 64'(rsp_cyc[i]), 64'(hs_cyc[i] + 2));
                chk($sformatf("bb%0d_rsp_data", i), rsp_dat[i], img1(b_addrs[i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
